// File: rtl/major_state_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : major_state_pkg
//  Description : Shared major-state codes, opcode codes and the exit decoder
//                used by the PDP-8/E major-state sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
package major_state_pkg;

    // Major/minor state codes. Logic refers to these names only.
    localparam logic [3:0] ST_F0 = 4'd0;
    localparam logic [3:0] ST_F1 = 4'd1;
    localparam logic [3:0] ST_F2 = 4'd2;
    localparam logic [3:0] ST_F3 = 4'd3;
    localparam logic [3:0] ST_D0 = 4'd4;
    localparam logic [3:0] ST_D1 = 4'd5;
    localparam logic [3:0] ST_D2 = 4'd6;
    localparam logic [3:0] ST_D3 = 4'd7;
    localparam logic [3:0] ST_E0 = 4'd8;
    localparam logic [3:0] ST_E1 = 4'd9;
    localparam logic [3:0] ST_E2 = 4'd10;
    localparam logic [3:0] ST_E3 = 4'd11;
    localparam logic [3:0] ST_H0 = 4'd12;

    // Instruction opcodes (IR[0:2]).
    localparam logic [2:0] OP_AND = 3'd0;
    localparam logic [2:0] OP_TAD = 3'd1;
    localparam logic [2:0] OP_ISZ = 3'd2;
    localparam logic [2:0] OP_DCA = 3'd3;
    localparam logic [2:0] OP_JMS = 3'd4;
    localparam logic [2:0] OP_JMP = 3'd5;
    localparam logic [2:0] OP_IOT = 3'd6;
    localparam logic [2:0] OP_OPR = 3'd7;

    // Where a major cycle goes when its last minor step finishes.
    typedef enum logic [1:0] {
        EXIT_END   = 2'd0,
        EXIT_DEFER = 2'd1,
        EXIT_EXEC  = 2'd2
    } exit_t;

    // Exit target from fetch (in_defer=0) or defer (in_defer=1).
    // Memory-reference instructions are everything except IOT and OPR;
    // of those, only JMP finishes without an execute cycle.
    function automatic exit_t next_major(input logic [2:0] op,
                                         input logic       indirect,
                                         input logic       in_defer);
        logic is_mri;
        logic is_data_mri;
        exit_t result;
        is_mri      = (op != OP_IOT) && (op != OP_OPR);
        is_data_mri = is_mri && (op != OP_JMP);
        result      = EXIT_END;
        if (!in_defer && is_mri && indirect) begin
            result = EXIT_DEFER;
        end else if (is_data_mri) begin
            result = EXIT_EXEC;
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/major_state.sv
`default_nettype none
// ============================================================================
//  Module      : major_state
//  Description : PDP-8/E major-state sequencer. Steps F/D/E minor states,
//                chooses the next major cycle from the IR and handles the
//                run/halt/single-step front-panel control.
//  Revision    : 1.0  initial release
// ============================================================================
module major_state
    import major_state_pkg::*;
#(
    parameter bit RESET_RUN = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [0:11] instruction,
    input  logic        run,
    input  logic        halt_req,
    output logic [3:0]  state,
    output logic        running,
    output logic        instr_done
);

    logic [3:0] r_state;
    logic       r_running;
    logic       r_done;

    logic [2:0] w_opcode;
    logic       w_indirect;
    logic       w_unused_operand;
    logic [3:0] w_next_state;
    logic       w_next_running;
    logic       w_next_done;
    logic       w_end_instr;

    assign w_opcode         = instruction[0:2];
    assign w_indirect       = instruction[3];
    assign w_unused_operand = ^instruction[4:11];

    // Next-state decode: minor stepping, major exits and end-of-instruction.
    always_comb begin
        w_next_state   = ST_H0;
        w_next_running = 1'b0;
        w_next_done    = 1'b0;
        w_end_instr    = 1'b0;
        case (r_state)
            ST_F0: begin w_next_state = ST_F1; w_next_running = 1'b1; end
            ST_F1: begin w_next_state = ST_F2; w_next_running = 1'b1; end
            ST_F2: begin w_next_state = ST_F3; w_next_running = 1'b1; end
            ST_F3: begin
                w_next_running = 1'b1;
                case (next_major(w_opcode, w_indirect, 1'b0))
                    EXIT_DEFER: w_next_state = ST_D0;
                    EXIT_EXEC:  w_next_state = ST_E0;
                    default:    w_end_instr  = 1'b1;
                endcase
            end
            ST_D0: begin w_next_state = ST_D1; w_next_running = 1'b1; end
            ST_D1: begin w_next_state = ST_D2; w_next_running = 1'b1; end
            ST_D2: begin w_next_state = ST_D3; w_next_running = 1'b1; end
            ST_D3: begin
                w_next_running = 1'b1;
                if (next_major(w_opcode, w_indirect, 1'b1) == EXIT_EXEC) begin
                    w_next_state = ST_E0;
                end else begin
                    w_end_instr = 1'b1;
                end
            end
            ST_E0: begin w_next_state = ST_E1; w_next_running = 1'b1; end
            ST_E1: begin w_next_state = ST_E2; w_next_running = 1'b1; end
            ST_E2: begin w_next_state = ST_E3; w_next_running = 1'b1; end
            ST_E3: w_end_instr = 1'b1;
            ST_H0: begin
                if (run) begin
                    w_next_state   = ST_F0;
                    w_next_running = 1'b1;
                end
            end
            // Illegal codes fall back to H0 with no completion pulse.
            default: begin
                w_next_state   = ST_H0;
                w_next_running = 1'b0;
            end
        endcase

        // halt_req is only looked at here, so a cycle is never truncated.
        if (w_end_instr) begin
            w_next_done = 1'b1;
            if (halt_req) begin
                w_next_state   = ST_H0;
                w_next_running = 1'b0;
            end else begin
                w_next_state   = ST_F0;
                w_next_running = 1'b1;
            end
        end
    end

    // State and output registers; reset aborts the current cycle at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= RESET_RUN ? ST_F0 : ST_H0;
            r_running <= RESET_RUN;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_running <= w_next_running;
            r_done    <= w_next_done;
        end
    end

    assign state      = r_state;
    assign running    = r_running;
    assign instr_done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_major_state.sv
`default_nettype none
// ============================================================================
//  Module      : tb_major_state
//  Description : Scoreboard bench for major_state. A driver applies directed
//                and random stimulus and pushes the expected outputs from an
//                instruction-level reference model; a monitor pops and
//                compares after every clock edge.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_major_state;
    import major_state_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [0:11] instruction;
    logic        run;
    logic        halt_req;
    logic [3:0]  state;
    logic        running;
    logic        instr_done;

    major_state dut (
        .clk         (clk),
        .reset       (reset),
        .instruction (instruction),
        .run         (run),
        .halt_req    (halt_req),
        .state       (state),
        .running     (running),
        .instr_done  (instr_done)
    );

    always #5 clk = ~clk;

    // mode: 1 = compare everything, 2 = compare running/instr_done only
    typedef struct {
        logic [3:0] st;
        logic       rn;
        logic       dn;
        int         mode;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    // ---------------- reference model (instruction level) ----------------
    logic [3:0] m_cur;
    logic       m_run;
    logic       m_done;
    logic [3:0] m_seq[$];
    int         cur_instr = 0;

    function automatic bit is_legal(logic [3:0] s);
        logic [3:0] legal[13] = '{ST_F0, ST_F1, ST_F2, ST_F3, ST_D0, ST_D1,
                                  ST_D2, ST_D3, ST_E0, ST_E1, ST_E2, ST_E3, ST_H0};
        for (int i = 0; i < 13; i++) if (legal[i] == s) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void m_reset();
        m_cur  = ST_H0;
        m_run  = 1'b0;
        m_done = 1'b0;
        m_seq.delete();
    endfunction

    // Advance the model by one clock with the inputs seen at that edge.
    function automatic void m_edge(int instr_v, bit rn, bit hr);
        int op       = (instr_v >> 9) & 7;
        bit ind      = ((instr_v >> 8) & 1) == 1;
        bit end_i    = 1'b0;
        logic [3:0] ext[$];
        m_done = 1'b0;
        if (!is_legal(m_cur)) begin
            m_cur = ST_H0;
            m_run = 1'b0;
            m_seq.delete();
        end else if (m_cur == ST_H0) begin
            if (rn) begin
                m_cur = ST_F0;
                m_run = 1'b1;
                m_seq = '{ST_F1, ST_F2, ST_F3};
            end
        end else if (m_seq.size() > 0) begin
            m_cur = m_seq.pop_front();
        end else if (m_cur == ST_F3) begin
            if (ind && op <= 5) ext = '{ST_D0, ST_D1, ST_D2, ST_D3};
            if (op <= 4) begin
                ext.push_back(ST_E0); ext.push_back(ST_E1);
                ext.push_back(ST_E2); ext.push_back(ST_E3);
            end
            if (ext.size() > 0) begin
                m_cur = ext.pop_front();
                m_seq = ext;
            end else begin
                end_i = 1'b1;
            end
        end else begin
            end_i = 1'b1;
        end
        if (end_i) begin
            m_done = 1'b1;
            if (hr) begin
                m_cur = ST_H0;
                m_run = 1'b0;
                m_seq.delete();
            end else begin
                m_cur = ST_F0;
                m_run = 1'b1;
                m_seq = '{ST_F1, ST_F2, ST_F3};
            end
        end
    endfunction

    // ---------------- driver helpers ----------------
    // New instructions are only loaded at F0/H0 so the IR is stable by F3.
    task automatic step(int instr_v, bit rn, bit hr);
        exp_t e;
        @(negedge clk);
        if (m_cur == ST_F0 || m_cur == ST_H0) cur_instr = instr_v & 12'o7777;
        reset       = 1'b1;
        instruction = cur_instr[11:0];
        run         = rn;
        halt_req    = hr;
        m_edge(cur_instr, rn, hr);
        e = '{st: m_cur, rn: m_run, dn: m_done, mode: 1};
        sb.push_back(e);
    endtask

    task automatic run_for(int instr_v, bit rn, bit hr, int n);
        for (int i = 0; i < n; i++) step(instr_v, rn, hr);
    endtask

    task automatic do_reset();
        exp_t e;
        @(negedge clk);
        reset = 1'b0;
        m_reset();
        #1;
        n_vec++;
        if (state !== ST_H0 || running !== 1'b0 || instr_done !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset state/running/done got %0d/%0d/%0d want %0d/0/0",
                     state, running, instr_done, ST_H0);
        end
        e = '{st: ST_H0, rn: 1'b0, dn: 1'b0, mode: 1};
        sb.push_back(e);
        @(negedge clk);
        sb.push_back(e);
    endtask

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_vec++;
                if ((e.mode == 1 && (state !== e.st || running !== e.rn || instr_done !== e.dn)) ||
                    (e.mode == 2 && (running !== e.rn || instr_done !== e.dn))) begin
                    n_err++;
                    $display("FAIL cycle t=%0t state/running/done got %0d/%0d/%0d want %0d/%0d/%0d",
                             $time, state, running, instr_done, e.st, e.rn, e.dn);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        exp_t e;
        int   guard;
        reset       = 1'b0;
        run         = 1'b0;
        halt_req    = 1'b0;
        instruction = '0;
        m_reset();

        // Reset, idle in H0, then run into free-running OPR.
        do_reset();
        run_for(12'o7000, 1'b0, 1'b0, 2);
        run_for(12'o7000, 1'b1, 1'b0, 9);

        // JMP I, JMP direct, ISZ, JMS, TAD I.
        run_for(12'o5455, 1'b1, 1'b0, 12);
        run_for(12'o5177, 1'b1, 1'b0, 8);
        run_for(12'o2000, 1'b1, 1'b0, 12);
        run_for(12'o4000, 1'b1, 1'b0, 12);
        run_for(12'o1400, 1'b1, 1'b0, 16);

        // halt_req raised in E1 of ISZ: finish E2/E3 then drop to H0.
        guard = 0;
        while (m_cur != ST_F0 && guard < 20) begin step(12'o2000, 1'b1, 1'b0); guard++; end
        guard = 0;
        while (m_cur != ST_E1 && guard < 20) begin step(12'o2000, 1'b1, 1'b0); guard++; end
        guard = 0;
        while (m_cur != ST_H0 && guard < 20) begin step(12'o2000, 1'b1, 1'b1); guard++; end
        // Single step one OPR from H0.
        step(12'o7000, 1'b1, 1'b1);
        run_for(12'o7000, 1'b0, 1'b1, 6);

        // Reset asserted in the middle of a defer cycle.
        guard = 0;
        while (m_cur != ST_D2 && guard < 30) begin step(12'o5455, 1'b1, 1'b0); guard++; end
        do_reset();

        // Illegal state code recovers to H0 with no completion pulse.
        @(negedge clk);
        reset = 1'b1;
        run   = 1'b0;
        force dut.r_state = 4'd14;
        m_cur = 4'd14;
        m_edge(cur_instr, 1'b0, 1'b0);
        e = '{st: m_cur, rn: m_run, dn: m_done, mode: 2};
        sb.push_back(e);
        @(negedge clk);
        release dut.r_state;
        m_edge(cur_instr, 1'b0, 1'b0);
        e = '{st: m_cur, rn: m_run, dn: m_done, mode: 1};
        sb.push_back(e);
        run_for(12'o7000, 1'b0, 1'b0, 2);

        // Randomized instruction mix with random run/halt_req levels.
        for (int i = 0; i < 800; i++) begin
            step(int'($urandom & 12'o7777), ($urandom % 4) != 0, ($urandom % 8) == 0);
        end

        guard = 0;
        while (sb.size() > 0 && guard < 10) begin @(posedge clk); guard++; end
        #5;
        if (sb.size() > 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain pending got %0d want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
